// File: rtl/rv32i_decode_ctrl.sv
// rv32i_decode_ctrl: RV32I control + immediate decode behind a registered ID/EX stage; DECODE_TRACE_EN adds a per-instruction trace.
module rv32i_decode_ctrl #(
  parameter logic RESET_OUT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  output logic [4:0]  rd_addr_o,
  output logic [2:0]  funct3_o,
  output logic [3:0]  alu_op_o,
  output logic        alu_src_o,
  output logic [1:0]  op_a_sel_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        branch_o,
  output logic        jump_o,
  output logic        reg_write_o,
  output logic [1:0]  mem_to_reg_o,
  output logic        illegal_o
);
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [1:0]  op_a;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic        illegal;
  } ctrl_t;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
    OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
    OP_IMM = 7'b0010011, OP_OP = 7'b0110011, OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;
  localparam logic [3:0] ALU_SUB = 4'd1;
  ctrl_t d, q;
  logic ill;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  // funct3 -> ALU op shared by OP and OP-IMM; sra picks the arithmetic right shift
  function automatic logic [3:0] alu_map(input logic [2:0] fn, input logic sra);
    case (fn)
      3'b000:  return 4'd0;
      3'b001:  return 4'd2;
      3'b010:  return 4'd3;
      3'b011:  return 4'd4;
      3'b100:  return 4'd5;
      3'b101:  return sra ? 4'd7 : 4'd6;
      3'b110:  return 4'd8;
      default: return 4'd9;
    endcase
  endfunction
  always_comb begin
    d = '0;
    ill = 1'b0;
    d.valid = 1'b1;
    d.pc = pc_i;
    d.rs1 = instr_i[19:15];
    d.rs2 = instr_i[24:20];
    d.rd = instr_i[11:7];
    d.funct3 = f3;
    case (op)
      OP_LUI: begin
        d.imm = imm_u; d.op_a = 2'b10; d.alu_src = 1'b1; d.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        d.imm = imm_u; d.op_a = 2'b01; d.alu_src = 1'b1; d.reg_write = 1'b1;
      end
      OP_JAL: begin
        d.imm = imm_j; d.op_a = 2'b01; d.alu_src = 1'b1; d.reg_write = 1'b1; d.jump = 1'b1; d.mem_to_reg = 2'b10;
      end
      OP_JALR: begin
        d.imm = imm_i; d.alu_src = 1'b1; d.reg_write = 1'b1; d.jump = 1'b1; d.mem_to_reg = 2'b10;
        ill = f3 != 3'b000;
      end
      OP_BRANCH: begin
        d.imm = imm_b; d.alu_op = ALU_SUB; d.branch = 1'b1;
        ill = f3 == 3'b010 || f3 == 3'b011;
      end
      OP_LOAD: begin
        d.imm = imm_i; d.alu_src = 1'b1; d.mem_read = 1'b1; d.reg_write = 1'b1; d.mem_to_reg = 2'b01;
        ill = f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111;
      end
      OP_STORE: begin
        d.imm = imm_s; d.alu_src = 1'b1; d.mem_write = 1'b1;
        ill = f3 >= 3'b011;
      end
      OP_IMM: begin
        d.imm = imm_i; d.alu_src = 1'b1; d.reg_write = 1'b1; d.alu_op = alu_map(f3, f7[5]);
        ill = (f3 == 3'b001 && f7 != 7'b0) || (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000);
      end
      OP_OP: begin
        d.reg_write = 1'b1;
        d.alu_op = (f7[5] && f3 == 3'b000) ? ALU_SUB : alu_map(f3, f7[5]);
        ill = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OP_FENCE, OP_SYSTEM: ;
      default: ill = 1'b1;
    endcase
    // an illegal instruction leaves no side effects and carries no operand control
    if (ill) begin
      d.imm = '0; d.alu_op = '0; d.alu_src = 1'b0; d.op_a = '0; d.mem_to_reg = '0;
      d.mem_read = 1'b0; d.mem_write = 1'b0; d.branch = 1'b0; d.jump = 1'b0; d.reg_write = 1'b0;
    end
    d.illegal = ill;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) q <= {$bits(ctrl_t){RESET_OUT}};
    else if (flush_i) q <= '0;
    else if (!stall_i) q <= valid_i ? d : '0;
  end
`ifdef DECODE_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst_n && valid_i && instr_i != 32'h0000_0013) begin
      if (op == OP_LUI) $display("decode pc=%h instr=%h opcode=%b rd=%0d imm=%h", pc_i, instr_i, op, instr_i[11:7], imm_u);
      else $display("decode pc=%h instr=%h opcode=%b rd=%0d", pc_i, instr_i, op, instr_i[11:7]);
    end
  end
`else
`endif
  assign valid_o = q.valid;
  assign pc_o = q.pc;
  assign imm_o = q.imm;
  assign rs1_addr_o = q.rs1;
  assign rs2_addr_o = q.rs2;
  assign rd_addr_o = q.rd;
  assign funct3_o = q.funct3;
  assign alu_op_o = q.alu_op;
  assign alu_src_o = q.alu_src;
  assign op_a_sel_o = q.op_a;
  assign mem_read_o = q.mem_read;
  assign mem_write_o = q.mem_write;
  assign branch_o = q.branch;
  assign jump_o = q.jump;
  assign reg_write_o = q.reg_write;
  assign mem_to_reg_o = q.mem_to_reg;
  assign illegal_o = q.illegal;
endmodule

// File: tb/tb_rv32i_decode_ctrl.sv
// tb_rv32i_decode_ctrl: directed vectors with a queued scoreboard for rv32i_decode_ctrl.
module tb_rv32i_decode_ctrl;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [1:0]  op_a;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic        illegal;
  } out_t;
  logic clk = 1'b0, rst_n = 1'b0, valid_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  logic [31:0] instr_i = '0, pc_i = '0;
  logic valid_o, alu_src_o, mem_read_o, mem_write_o, branch_o, jump_o, reg_write_o, illegal_o;
  logic [31:0] pc_o, imm_o;
  logic [4:0] rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [2:0] funct3_o;
  logic [3:0] alu_op_o;
  logic [1:0] op_a_sel_o, mem_to_reg_o;
  out_t act, e, hold;
  out_t exp_q[$];
  string name_q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  rv32i_decode_ctrl dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .instr_i(instr_i), .pc_i(pc_i), .valid_o(valid_o), .pc_o(pc_o), .imm_o(imm_o),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o), .funct3_o(funct3_o),
    .alu_op_o(alu_op_o), .alu_src_o(alu_src_o), .op_a_sel_o(op_a_sel_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .branch_o(branch_o), .jump_o(jump_o), .reg_write_o(reg_write_o),
    .mem_to_reg_o(mem_to_reg_o), .illegal_o(illegal_o)
  );
  assign act = '{valid_o, pc_o, imm_o, rs1_addr_o, rs2_addr_o, rd_addr_o, funct3_o, alu_op_o, alu_src_o,
                 op_a_sel_o, mem_read_o, mem_write_o, branch_o, jump_o, reg_write_o, mem_to_reg_o, illegal_o};
  function automatic out_t base(input logic [31:0] ins, input logic [31:0] p);
    out_t b = '0;
    b.valid = 1'b1;
    b.pc = p;
    b.rs1 = ins[19:15];
    b.rs2 = ins[24:20];
    b.rd = ins[11:7];
    b.funct3 = ins[14:12];
    return b;
  endfunction
  task automatic step(input logic r, input logic v, input logic s, input logic f,
                      input logic [31:0] ins, input logic [31:0] p, input out_t ex, input string nm);
    @(negedge clk);
    rst_n = r; valid_i = v; stall_i = s; flush_i = f; instr_i = ins; pc_i = p;
    exp_q.push_back(ex);
    name_q.push_back(nm);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        out_t x;
        string n;
        x = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (act !== x) begin
          errors++;
          $display("FAIL %s: got %h expected %h", n, act, x);
        end
      end
    end
  end
  initial begin
    step(0, 1, 0, 0, 32'h12345137, 32'h100, '0, "reset0");
    step(0, 1, 0, 0, 32'h12345137, 32'h100, '0, "reset1");
    e = base(32'h12345137, 32'h100); e.imm = 32'h12345000; e.op_a = 2'b10; e.alu_src = 1; e.reg_write = 1;
    step(1, 1, 0, 0, 32'h12345137, 32'h100, e, "lui");
    e = base(32'hFFF00093, 32'h104); e.imm = 32'hFFFFFFFF; e.alu_src = 1; e.reg_write = 1;
    step(1, 1, 0, 0, 32'hFFF00093, 32'h104, e, "addi");
    e = base(32'h402081B3, 32'h108); e.alu_op = 4'd1; e.reg_write = 1;
    step(1, 1, 0, 0, 32'h402081B3, 32'h108, e, "sub");
    e = base(32'h0020A423, 32'h10C); e.imm = 32'd8; e.alu_src = 1; e.mem_write = 1;
    step(1, 1, 0, 0, 32'h0020A423, 32'h10C, e, "sw");
    e = base(32'h0040A183, 32'h110); e.imm = 32'd4; e.alu_src = 1; e.mem_read = 1; e.reg_write = 1; e.mem_to_reg = 2'b01;
    step(1, 1, 0, 0, 32'h0040A183, 32'h110, e, "lw");
    e = base(32'hFE000EE3, 32'h114); e.imm = 32'hFFFFFFFC; e.alu_op = 4'd1; e.branch = 1;
    step(1, 1, 0, 0, 32'hFE000EE3, 32'h114, e, "beq");
    e = base(32'h008000EF, 32'h118); e.imm = 32'd8; e.jump = 1; e.reg_write = 1; e.mem_to_reg = 2'b10; e.op_a = 2'b01; e.alu_src = 1;
    step(1, 1, 0, 0, 32'h008000EF, 32'h118, e, "jal");
    e = base(32'hFFFFFFFF, 32'h11C); e.illegal = 1;
    step(1, 1, 0, 0, 32'hFFFFFFFF, 32'h11C, e, "bad_opcode");
    e = base(32'h0220D1B3, 32'h120); e.illegal = 1;
    step(1, 1, 0, 0, 32'h0220D1B3, 32'h120, e, "bad_funct7");
    hold = e;
    step(1, 1, 1, 0, 32'hFFF00093, 32'h124, hold, "stall0");
    step(1, 1, 1, 0, 32'h12345137, 32'h128, hold, "stall1");
    e = base(32'h40335293, 32'h12C); e.imm = 32'h00000403; e.alu_op = 4'd7; e.alu_src = 1; e.reg_write = 1;
    step(1, 1, 0, 0, 32'h40335293, 32'h12C, e, "srai");
    step(1, 1, 1, 1, 32'h008000EF, 32'h130, '0, "flush_stall");
    e = base(32'h00001517, 32'h134); e.imm = 32'h00001000; e.op_a = 2'b01; e.alu_src = 1; e.reg_write = 1;
    step(1, 1, 0, 0, 32'h00001517, 32'h134, e, "auipc");
    step(1, 0, 0, 0, 32'h00001517, 32'h138, '0, "invalid_in");
    e = base(32'h0000E183, 32'h13C); e.illegal = 1;
    step(1, 1, 0, 0, 32'h0000E183, 32'h13C, e, "bad_load_f3");
    step(0, 1, 0, 0, 32'h00001517, 32'h140, '0, "reset_again");
    step(1, 0, 0, 0, 32'h0, 32'h0, '0, "idle");
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
